// File: rtl/av2_mv_decoder_multi_if.sv
// Bus bundle for the motion-vector decoder: control, predictors, the
// entropy-decoder symbol port and the decoded-vector output port.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. Once the producer raises valid it holds valid and the
// payload stable until that edge. The producer never waits for ready
// before raising valid. Symbol port: decoder -> symbol_ready,
// source -> symbol_valid/decoded_symbol. Vector port: decoder ->
// mv_valid/mv_x/mv_y/mv_idx, consumer -> mv_ready.
interface av2_mv_decoder_multi_if #(
  parameter int MV_W   = 16,
  parameter int NUM_MV = 2
);
  logic                     start;
  logic                     flush;
  logic [NUM_MV*MV_W-1:0]   pred_x;
  logic [NUM_MV*MV_W-1:0]   pred_y;
  logic [15:0]              decoded_symbol;
  logic                     symbol_valid;
  logic                     symbol_ready;
  // Vector components are two's complement values.
  logic [MV_W-1:0]          mv_x;
  logic [MV_W-1:0]          mv_y;
  logic [1:0]               mv_idx;
  logic                     mv_valid;
  logic                     mv_ready;
  logic                     busy;
  logic                     done;

  // Environment side: drives control, predictors, symbols and mv_ready.
  modport master (
    output start, flush, pred_x, pred_y, decoded_symbol, symbol_valid, mv_ready,
    input  symbol_ready, mv_x, mv_y, mv_idx, mv_valid, busy, done
  );

  // Decoder side.
  modport slave (
    input  start, flush, pred_x, pred_y, decoded_symbol, symbol_valid, mv_ready,
    output symbol_ready, mv_x, mv_y, mv_idx, mv_valid, busy, done
  );
endinterface

// File: rtl/av2_mv_decoder_multi.sv
// Motion-vector decoder: reads length-coded signed differences from the
// entropy-decoder symbol stream (x then y per vector), adds them to the
// latched predictors with saturation and presents up to NUM_MV vectors.
// state_dbg encoding: 0 IDLE, 1 CLASS, 2 MAG, 3 SIGN, 4 ADD, 5 OUT, 6 DONE.
module av2_mv_decoder_multi #(
  parameter int MV_W     = 16,
  parameter int MAG_BITS = 12,
  parameter int NUM_MV   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  av2_mv_decoder_multi_if.slave bus,
  output logic [2:0]            state_dbg
);

  // Differences and sums carry one extra bit so pred+diff never wraps
  // (MAG_BITS < MV_W keeps the magnitude well inside this range).
  localparam int DW = MV_W + 1;
  // Length and bit counter are 5 bits: the class field gives at most 16.
  localparam logic [4:0] MAG_LEN_MAX = 5'(MAG_BITS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLASS = 3'd1,
    S_MAG   = 3'd2,
    S_SIGN  = 3'd3,
    S_ADD   = 3'd4,
    S_OUT   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             vec_q, vec_d;        // vector being decoded
  logic                   comp_q, comp_d;      // 0: x component, 1: y
  logic [4:0]             len_q, len_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [MAG_BITS-1:0]    mag_q, mag_d;
  logic [DW-1:0]          diff_x_q, diff_x_d;
  logic [DW-1:0]          diff_y_q, diff_y_d;
  logic [NUM_MV*MV_W-1:0] pred_x_q, pred_x_d;
  logic [NUM_MV*MV_W-1:0] pred_y_q, pred_y_d;
  logic [MV_W-1:0]        mv_x_q, mv_x_d;
  logic [MV_W-1:0]        mv_y_q, mv_y_d;
  logic [1:0]             mv_idx_q, mv_idx_d;
  logic                   mv_valid_q, mv_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   sym_ready;
  logic                   sym_fire;
  logic [4:0]             len_raw;
  logic [4:0]             len_clamp;
  logic [DW-1:0]          mag_ext;
  logic [DW-1:0]          diff_val;
  logic [MV_W-1:0]        px_sel;
  logic [MV_W-1:0]        py_sel;
  logic [DW-1:0]          sum_x;
  logic [DW-1:0]          sum_y;
  logic                   last_vec;
  logic                   unused_sym;

  // Clamp a widened sum into the signed MV_W range.
  function automatic logic [MV_W-1:0] sat_mv(input logic [DW-1:0] s);
    if (s[DW-1] != s[DW-2]) begin
      sat_mv = s[DW-1] ? {1'b1, {(MV_W-1){1'b0}}} : {1'b0, {(MV_W-1){1'b1}}};
    end else begin
      sat_mv = s[MV_W-1:0];
    end
  endfunction

  // Only bit 0 (and bits 4:1 in CLASS) of a symbol carry information.
  assign unused_sym = ^bus.decoded_symbol[15:5];

  // Datapath helpers shared by the next-state logic.
  always_comb begin
    sym_ready = (state_q == S_CLASS) || (state_q == S_MAG) || (state_q == S_SIGN);
    sym_fire  = sym_ready && bus.symbol_valid;
    len_raw   = {1'b0, bus.decoded_symbol[4:1]} + 5'd1;
    len_clamp = (len_raw > MAG_LEN_MAX) ? MAG_LEN_MAX : len_raw;
    mag_ext   = {{(DW-MAG_BITS){1'b0}}, mag_q};
    // Negating a zero magnitude yields zero, so the sign of 0 is harmless.
    diff_val  = bus.decoded_symbol[0] ? (DW'(0) - mag_ext) : mag_ext;
    px_sel    = pred_x_q[int'(vec_q)*MV_W +: MV_W];
    py_sel    = pred_y_q[int'(vec_q)*MV_W +: MV_W];
    sum_x     = {px_sel[MV_W-1], px_sel} + diff_x_q;
    sum_y     = {py_sel[MV_W-1], py_sel} + diff_y_q;
    last_vec  = (vec_q == 2'(NUM_MV-1));
  end

  // Next-state and register-update logic; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    comp_d     = comp_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    diff_x_d   = diff_x_q;
    diff_y_d   = diff_y_q;
    pred_x_d   = pred_x_q;
    pred_y_d   = pred_y_q;
    mv_x_d     = mv_x_q;
    mv_y_d     = mv_y_q;
    mv_idx_d   = mv_idx_q;
    mv_valid_d = mv_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pred_x_d = bus.pred_x;
          pred_y_d = bus.pred_y;
          vec_d    = 2'd0;
          comp_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_CLASS;
        end
      end
      S_CLASS: begin
        if (sym_fire) begin
          if (bus.decoded_symbol[0]) begin
            // Zero-component shortcut: no magnitude or sign follows.
            if (comp_q) begin
              diff_y_d = '0;
              state_d  = S_ADD;
            end else begin
              diff_x_d = '0;
              comp_d   = 1'b1;
            end
          end else begin
            len_d   = len_clamp;
            cnt_d   = 5'd0;
            mag_d   = '0;
            state_d = S_MAG;
          end
        end
      end
      S_MAG: begin
        if (sym_fire) begin
          // Magnitude bits arrive LSB first.
          for (int i = 0; i < MAG_BITS; i++) begin
            if (cnt_q == 5'(i)) begin
              mag_d[i] = bus.decoded_symbol[0];
            end
          end
          cnt_d = cnt_q + 5'd1;
          if ((cnt_q + 5'd1) == len_q) begin
            state_d = S_SIGN;
          end
        end
      end
      S_SIGN: begin
        if (sym_fire) begin
          if (comp_q) begin
            diff_y_d = diff_val;
            state_d  = S_ADD;
          end else begin
            diff_x_d = diff_val;
            comp_d   = 1'b1;
            state_d  = S_CLASS;
          end
        end
      end
      S_ADD: begin
        mv_x_d     = sat_mv(sum_x);
        mv_y_d     = sat_mv(sum_y);
        mv_idx_d   = vec_q;
        mv_valid_d = 1'b1;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (bus.mv_ready) begin
          mv_valid_d = 1'b0;
          if (last_vec) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            vec_d   = vec_q + 2'd1;
            comp_d  = 1'b0;
            state_d = S_CLASS;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.flush) begin
      state_d    = S_IDLE;
      mv_valid_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      vec_q      <= '0;
      comp_q     <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      mag_q      <= '0;
      diff_x_q   <= '0;
      diff_y_q   <= '0;
      pred_x_q   <= '0;
      pred_y_q   <= '0;
      mv_x_q     <= '0;
      mv_y_q     <= '0;
      mv_idx_q   <= '0;
      mv_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      comp_q     <= comp_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      diff_x_q   <= diff_x_d;
      diff_y_q   <= diff_y_d;
      pred_x_q   <= pred_x_d;
      pred_y_q   <= pred_y_d;
      mv_x_q     <= mv_x_d;
      mv_y_q     <= mv_y_d;
      mv_idx_q   <= mv_idx_d;
      mv_valid_q <= mv_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.symbol_ready = sym_ready;
  assign bus.mv_x         = mv_x_q;
  assign bus.mv_y         = mv_y_q;
  assign bus.mv_idx       = mv_idx_q;
  assign bus.mv_valid     = mv_valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_av2_mv_decoder_multi.sv
// Bench for av2_mv_decoder_multi: a NUM_MV=1 instance for cycle-exact
// timing and a NUM_MV=2 instance driven from a symbol queue with a
// scoreboard of expected vectors built by an encoder-side model.
module tb_av2_mv_decoder_multi;
  localparam int MV_W     = 16;
  localparam int MAG_BITS = 12;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLASS = 3'd1;
  localparam logic [2:0] ST_MAG   = 3'd2;
  localparam logic [2:0] ST_ADD   = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  av2_mv_decoder_multi_if #(.MV_W(MV_W), .NUM_MV(2)) bus2 ();
  av2_mv_decoder_multi_if #(.MV_W(MV_W), .NUM_MV(1)) bus1 ();
  logic [2:0] state2;
  logic [2:0] state1;

  av2_mv_decoder_multi #(.MV_W(MV_W), .MAG_BITS(MAG_BITS), .NUM_MV(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .state_dbg(state2)
  );
  av2_mv_decoder_multi #(.MV_W(MV_W), .MAG_BITS(MAG_BITS), .NUM_MV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .state_dbg(state1)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] sym_q[$];
  logic [33:0] exp_q[$];     // {idx[1:0], x[15:0], y[15:0]}
  int  pred_x_a[2];
  int  pred_y_a[2];
  bit  gap_en   = 1'b0;
  int  rdy_mode = 0;          // 0 high, 1 random, 2 low
  int  done_cnt = 0;
  int  mag_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Encode one component into symbols; junk upper bits must be ignored.
  task automatic add_comp(input bit zero, input int lenf, input int mag, input bit neg,
                          output int diff);
    int len;
    int r;
    r = int'($urandom_range(0, 2047));
    if (zero) begin
      sym_q.push_back(16'((r << 1) | 1));
      diff = 0;
    end else begin
      sym_q.push_back(16'((r << 5) | ((lenf & 15) << 1)));
      len = (lenf + 1 > MAG_BITS) ? MAG_BITS : lenf + 1;
      for (int b = 0; b < len; b++) begin
        r = int'($urandom_range(0, 32767));
        sym_q.push_back(16'((r << 1) | ((mag >> b) & 1)));
      end
      r = int'($urandom_range(0, 32767));
      sym_q.push_back(16'((r << 1) | int'(neg)));
      diff = neg ? -mag : mag;
    end
  endtask

  task automatic add_vec(input int idx, input int px, input int py,
                         input bit zx, input int lx, input int mx, input bit nx,
                         input bit zy, input int ly, input int my, input bit ny);
    int dx;
    int dy;
    logic [15:0] ex;
    logic [15:0] ey;
    add_comp(zx, lx, mx, nx, dx);
    add_comp(zy, ly, my, ny, dy);
    ex = 16'(sat(px + dx));
    ey = 16'(sat(py + dy));
    exp_q.push_back({2'(idx), ex, ey});
    pred_x_a[idx] = px;
    pred_y_a[idx] = py;
  endtask

  task automatic start_block(output int base);
    bus2.pred_x = {16'(pred_x_a[1]), 16'(pred_x_a[0])};
    bus2.pred_y = {16'(pred_y_a[1]), 16'(pred_y_a[0])};
    base = done_cnt;
    @(posedge clk); #1 bus2.start = 1'b1;
    @(posedge clk); #1 bus2.start = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int t;
    t = 0;
    while (done_cnt == base && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("done_seen", 64'(done_cnt != base), 64'd1);
    repeat (4) @(posedge clk);
    check("done_once", 64'(done_cnt - base), 64'd1);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    check("sym_used", 64'(sym_q.size()), 64'd0);
  endtask

  task automatic wait_mv_valid();
    int t;
    t = 0;
    while (!bus2.mv_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("mv_valid_seen", 64'(bus2.mv_valid), 64'd1);
  endtask

  // Symbol source: pops a symbol after each accepted handshake.
  initial begin
    bit fire;
    logic [15:0] dummy;
    bus2.symbol_valid   = 1'b0;
    bus2.decoded_symbol = '0;
    forever begin
      @(negedge clk);
      fire = bus2.symbol_valid && bus2.symbol_ready;
      @(posedge clk);
      #1;
      if (fire && sym_q.size() > 0) dummy = sym_q.pop_front();
      if (sym_q.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
        bus2.symbol_valid   = 1'b1;
        bus2.decoded_symbol = sym_q[0];
      end else begin
        bus2.symbol_valid   = 1'b0;
        bus2.decoded_symbol = 16'($urandom_range(0, 65535));
      end
    end
  end

  // Output consumer ready.
  initial begin
    bus2.mv_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      bus2.mv_ready = 1'b1;
      else if (rdy_mode == 1) bus2.mv_ready = 1'($urandom_range(0, 1));
      else                    bus2.mv_ready = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  initial begin
    logic [33:0] got;
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (bus2.done) done_cnt++;
      if (state2 == ST_MAG && bus2.symbol_valid && bus2.symbol_ready) mag_cnt++;
      if (rst_n && bus2.mv_valid && bus2.mv_ready) begin
        got = {bus2.mv_idx, bus2.mv_x, bus2.mv_y};
        if (exp_q.size() == 0) begin
          check("mv_extra", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("mv_idx", 64'(got[33:32]), 64'(e[33:32]));
          check("mv_x", 64'(got[31:16]), 64'(e[31:16]));
          check("mv_y", 64'(got[15:0]), 64'(e[15:0]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int dummy;
    int px;
    int py;
    int zx;
    int zy;
    int lx;
    int ly;
    int mx;
    int my;
    int nx;
    int ny;
    int lenx;
    int leny;
    bus2.start = 1'b0; bus2.flush = 1'b0; bus2.pred_x = '0; bus2.pred_y = '0;
    bus1.start = 1'b0; bus1.flush = 1'b0;
    bus1.pred_x = 16'd5; bus1.pred_y = 16'hFFFD;
    bus1.symbol_valid = 1'b1; bus1.decoded_symbol = 16'h0001; bus1.mv_ready = 1'b1;
    pred_x_a = '{0, 0}; pred_y_a = '{0, 0};

    // Reset values.
    #2;
    check("rst_state", 64'(state2), 64'(ST_IDLE));
    check("rst_mv_valid", 64'(bus2.mv_valid), 64'd0);
    check("rst_mv_xy", 64'({bus2.mv_x, bus2.mv_y, bus2.mv_idx}), 64'd0);
    check("rst_busy_done", 64'({bus2.busy, bus2.done}), 64'd0);
    check("rst_sym_ready", 64'(bus2.symbol_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // NUM_MV=1 zero vector: cycle-exact timing.
    @(posedge clk); #1 bus1.start = 1'b1;
    @(posedge clk); #1 bus1.start = 1'b0;
    @(negedge clk);
    check("t1_c1_state", 64'(state1), 64'(ST_CLASS));
    check("t1_c1_busy", 64'(bus1.busy), 64'd1);
    @(negedge clk);
    check("t1_c2_state", 64'(state1), 64'(ST_CLASS));
    @(negedge clk);
    check("t1_c3_state", 64'(state1), 64'(ST_ADD));
    check("t1_c3_valid", 64'(bus1.mv_valid), 64'd0);
    check("t1_c3_sym_ready", 64'(bus1.symbol_ready), 64'd0);
    @(negedge clk);
    check("t1_c4_valid", 64'(bus1.mv_valid), 64'd1);
    check("t1_c4_x", 64'(bus1.mv_x), 64'h0005);
    check("t1_c4_y", 64'(bus1.mv_y), 64'hFFFD);
    check("t1_c4_idx", 64'(bus1.mv_idx), 64'd0);
    @(negedge clk);
    check("t1_c5_done", 64'(bus1.done), 64'd1);
    check("t1_c5_valid", 64'(bus1.mv_valid), 64'd0);
    check("t1_c5_busy", 64'(bus1.busy), 64'd1);
    @(negedge clk);
    check("t1_c6_done", 64'(bus1.done), 64'd0);
    check("t1_c6_busy", 64'(bus1.busy), 64'd0);
    bus1.symbol_valid = 1'b0;

    // X magnitude 5 negative, y zero; second vector zero.
    add_vec(0, 0, 0, 0, 2, 5, 1, 1, 0, 0, 0);
    add_vec(1, 3, 4, 1, 0, 0, 0, 1, 0, 0, 0);
    start_block(base);
    wait_done(base);

    // Saturation both directions.
    add_vec(0, 32760, 0, 0, 6, 100, 0, 1, 0, 0, 0);
    add_vec(1, -32760, 5, 0, 6, 100, 1, 0, 3, 15, 0);
    start_block(base);
    wait_done(base);

    // Length clamp to MAG_BITS; zero magnitude with negative sign.
    mag_cnt = 0;
    add_vec(0, 0, 0, 0, 15, 4095, 0, 1, 0, 0, 0);
    add_vec(1, 7, 8, 0, 0, 0, 1, 1, 0, 0, 0);
    start_block(base);
    wait_done(base);
    check("clamp_mag_syms", 64'(mag_cnt), 64'd13);

    // Output stall: vector 0 held stable while mv_ready is low.
    rdy_mode = 2;
    add_vec(0, 100, -200, 0, 3, 9, 0, 1, 0, 0, 0);
    add_vec(1, 1, 2, 1, 0, 0, 0, 0, 1, 3, 1);
    start_block(base);
    wait_mv_valid();
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", 64'(bus2.mv_valid), 64'd1);
      check("stall_idx", 64'(bus2.mv_idx), 64'(exp_q[0][33:32]));
      check("stall_x", 64'(bus2.mv_x), 64'(exp_q[0][31:16]));
      check("stall_y", 64'(bus2.mv_y), 64'(exp_q[0][15:0]));
      @(negedge clk);
    end
    rdy_mode = 0;
    wait_done(base);

    // Random blocks, each run gapless and then with symbol/ready gaps.
    for (int r = 0; r < 6; r++) begin
      for (int pass = 0; pass < 2; pass++) begin
        if (pass == 0) begin
          px = int'($urandom_range(0, 65535)) - 32768;
          py = int'($urandom_range(0, 65535)) - 32768;
          zx = ($urandom_range(0, 3) == 0); zy = ($urandom_range(0, 3) == 0);
          lx = int'($urandom_range(0, 15)); ly = int'($urandom_range(0, 15));
          lenx = (lx + 1 > MAG_BITS) ? MAG_BITS : lx + 1;
          leny = (ly + 1 > MAG_BITS) ? MAG_BITS : ly + 1;
          mx = int'($urandom_range(0, (1 << lenx) - 1));
          my = int'($urandom_range(0, (1 << leny) - 1));
          nx = int'($urandom_range(0, 1)); ny = int'($urandom_range(0, 1));
        end
        gap_en   = (pass == 1);
        rdy_mode = (pass == 1) ? 1 : 0;
        add_vec(0, px, py, 1'(zx), lx, mx, 1'(nx), 1'(zy), ly, my, 1'(ny));
        add_vec(1, py, px, 1'(zy), ly, my, 1'(ny), 1'(zx), lx, mx, 1'(nx));
        start_block(base);
        wait_done(base);
      end
    end
    gap_en = 1'b0;
    rdy_mode = 0;

    // Flush during MAG: back to IDLE, no done.
    add_comp(1'b0, 7, 200, 1'b0, dummy);
    start_block(base);
    begin
      int t;
      t = 0;
      while (state2 != ST_MAG && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    check("flush_in_mag", 64'(state2), 64'(ST_MAG));
    @(posedge clk); #1 bus2.flush = 1'b1;
    @(posedge clk); #1 bus2.flush = 1'b0;
    sym_q.delete();
    @(negedge clk);
    check("flush_state", 64'(state2), 64'(ST_IDLE));
    check("flush_busy", 64'(bus2.busy), 64'd0);
    check("flush_valid", 64'(bus2.mv_valid), 64'd0);
    check("flush_sym_ready", 64'(bus2.symbol_ready), 64'd0);
    repeat (10) @(negedge clk);
    check("flush_no_done", 64'(done_cnt - base), 64'd0);

    // Reset asserted while a vector waits in OUT.
    rdy_mode = 2;
    add_vec(0, 1000, 1000, 0, 4, 17, 0, 0, 2, 6, 1);
    add_vec(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    start_block(base);
    wait_mv_valid();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus2.mv_valid), 64'd0);
    check("rst_out_xy", 64'({bus2.mv_x, bus2.mv_y, bus2.mv_idx}), 64'd0);
    check("rst_out_busy_done", 64'({bus2.busy, bus2.done}), 64'd0);
    check("rst_out_state", 64'(state2), 64'(ST_IDLE));
    exp_q.delete();
    sym_q.delete();
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_out_no_done", 64'(done_cnt - base), 64'd0);

    // Recovery after reset.
    add_vec(0, -5, 9, 0, 1, 3, 0, 0, 0, 1, 1);
    add_vec(1, 11, -11, 1, 0, 0, 0, 0, 5, 33, 0);
    start_block(base);
    wait_done(base);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/av2_mv_decoder_multi.md
# av2_mv_decoder_multi

Parametrised motion-vector decoder that turns the entropy decoder's symbol stream into up to `NUM_MV` final motion vectors per block (single or compound prediction). Each vector is a signed difference added to a predictor. The block reads explicit length-coded magnitudes, supports zero-component shortcuts, and saturates each result. It sits between the entropy decoder symbol port and the inter-prediction MV consumer.

## Interface
- `MV_W`, 16: signed MV component width; `MAG_BITS` < `MV_W` is required.
- `MAG_BITS`, 12: maximum magnitude bits per component.
- `NUM_MV`, 2: vectors decoded per `start`; legal values are 1..4.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start` in 1: begin a block. Sampled only in IDLE; ignored otherwise.
- `flush` in 1: synchronous abort. Returns to IDLE next edge with no `done`; it has priority over `start`.
- `pred_x`, `pred_y` in `NUM_MV*MV_W`: signed predictors, vector i at bits [i*MV_W +: MV_W]. Latched on the accepted `start`.
- `decoded_symbol` in 16: symbol from the entropy decoder.
- `symbol_valid` in 1 / `symbol_ready` out 1: symbol handshake. A symbol is accepted when both are high.
- `mv_x`, `mv_y` out `MV_W` signed: final vector.
- `mv_idx` out 2: index of the vector currently presented.
- `mv_valid` out 1 / `mv_ready` in 1: output handshake.
- `busy` out 1: high from the accepted `start` through the DONE state.
- `done` out 1: one-cycle pulse after the last vector handshake.

## Operation
- States: IDLE, CLASS, MAG, SIGN, ADD, OUT, DONE. Components are decoded x then y for each vector. Vectors run 0..NUM_MV-1.
- CLASS accepts one symbol.
  - `decoded_symbol[0]`=1: component is zero. Go to CLASS for y, or to ADD after y.
  - `decoded_symbol[0]`=0: `len` = min(`decoded_symbol[4:1]`+1, `MAG_BITS`). Clear the magnitude and bit counter, then go to MAG.
- MAG accepts one symbol per bit. `decoded_symbol[0]` is placed at bit position `cnt`, LSB first. After `len` bits, go to SIGN.
- SIGN accepts one symbol.
  - `decoded_symbol[0]`=1 means negative.
  - The difference is ±magnitude, sign-extended to `MV_W`+1 bits. A zero magnitude gives 0 regardless of sign.
  - Next state is CLASS for y, or ADD after y.
- ADD takes one cycle with no symbol accepted.
  - Compute `pred`+`diff` in `MV_W`+1 bits per component.
  - Saturate to [-2^(MV_W-1), 2^(MV_W-1)-1].
  - Register `mv_x`, `mv_y` and `mv_idx`, set `mv_valid`, go to OUT.
- OUT: hold all outputs stable until `mv_ready`. On the handshake, clear `mv_valid`. Go to CLASS for the next vector, or to DONE after the last.
- DONE: `done`=1 for one cycle, `busy` clears, next state is IDLE.
- `symbol_ready` is combinational: 1 in CLASS, MAG and SIGN; 0 otherwise. Gaps in `symbol_valid` stall the state with no state change.
- `flush` in any state: clear `mv_valid` and `busy`, go to IDLE, no `done`. Partial results are discarded.

## Timing
- Reset: state IDLE. `mv_x`, `mv_y`, `mv_idx`, `mv_valid`, `busy` and `done` are all 0. `symbol_ready` is 0.
- Reset asserted mid-operation: immediate return to IDLE with the reset values above. No `done` and no `mv_valid` follow.
- `start` accepted at edge 0 puts CLASS in cycle 1.
- With both components zero and `symbol_valid` held high: x class accepted in cycle 1, y class in cycle 2, ADD in cycle 3, `mv_valid`=1 in cycle 4.
- A nonzero component costs 1 + `len` + 1 accepted symbols.
- Back-to-back vectors: the CLASS of the next vector is in the cycle after the OUT handshake.
- `done` is high in the cycle after the final handshake. `start` is accepted again from the following cycle.
- `mv_x`, `mv_y` and `mv_idx` are registered and stable whenever `mv_valid`=1.

## Test plan
- Zero vector, NUM_MV=1, pred (5,-3), symbols 0x0001, 0x0001, `mv_ready`=1 → `mv_valid` in cycle 4 with (5,-3), `mv_idx`=0, `done` in cycle 5.
- X magnitude, pred (0,0): 0x0004 (len 3), bits 1,0,1, sign 1, y class 0x0001 → mv (-5,0).
- Saturation, pred x=32760: class `len` 7, magnitude 100, sign 0 → `mv_x`=32767. Pred x=-32760 with negative magnitude 100 → -32768.
- Length clamp: class field 15 with MAG_BITS=12 → exactly 12 MAG symbols accepted, then SIGN. All-ones bits, positive → diff 4095.
- Compound, NUM_MV=2, `mv_ready` held low for 3 cycles on vector 0 → vector 0 outputs stable throughout; vector 1 presented with `mv_idx`=1; single `done` pulse after its handshake.
- Random `symbol_valid` gaps give results identical to the gapless run. `flush` during MAG → IDLE next cycle with no `done`. `rst_n` low during OUT → all outputs 0 immediately.
